// File: rtl/sha2_pkg.sv
// Shared widths, byte-enable encodings and FSM state encoding for the
// SHA-2 message sender.
package sha2_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned DGST_W = 256;
    localparam int unsigned LEN_W  = 64;

    localparam logic [3:0] BE_4B = 4'hf;
    localparam logic [3:0] BE_3B = 4'he;
    localparam logic [3:0] BE_2B = 4'hc;
    localparam logic [3:0] BE_1B = 4'h8;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_PACK      = 3'd2,
        ST_SEND      = 3'd3,
        ST_WAIT_DGST = 3'd4,
        ST_RESULT    = 3'd5
    } sha2_state_e;

    // An empty word reports no enables.
    function automatic logic [3:0] be_from_cnt(input logic [2:0] cnt);
        logic [3:0] be;
        be = '0;
        case (cnt)
            3'd4:    be = BE_4B;
            3'd3:    be = BE_3B;
            3'd2:    be = BE_2B;
            3'd1:    be = BE_1B;
            default: be = '0;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/sha2_byte_packer.sv
// Packs bytes MSB-first into a 32-bit word; unfilled bytes remain zero
// until the next clear.
module sha2_byte_packer
    import sha2_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              byte_vld,
    input  logic [7:0]        byte_dat,
    output logic [WORD_W-1:0] word,
    output logic [2:0]        byte_cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word     <= '0;
            byte_cnt <= '0;
        end else if (clr) begin
            word     <= '0;
            byte_cnt <= '0;
        end else if (byte_vld) begin
            case (byte_cnt)
                3'd0:    word[31:24] <= byte_dat;
                3'd1:    word[23:16] <= byte_dat;
                3'd2:    word[15:8]  <= byte_dat;
                default: word[7:0]   <= byte_dat;
            endcase
            byte_cnt <= byte_cnt + 3'd1;
        end
    end

endmodule

// File: rtl/sha2_msg_sender.sv
// Feeds a byte-stream message to a SHA-2 core one word at a time and
// returns the resulting digest; one job in flight at a time.
module sha2_msg_sender
    import sha2_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_vld,
    input  logic [31:0]       cmd_len,
    output logic              cmd_rdy,
    input  logic              in_vld,
    input  logic [7:0]        in_dat,
    output logic              in_rdy,
    output logic              start_p,
    output logic [LEN_W-1:0]  msg_len,
    output logic              msg_vld,
    output logic [WORD_W-1:0] msg_dat,
    output logic [3:0]        msg_be,
    output logic              msg_lst,
    input  logic              msg_rdy,
    input  logic              dgst_done,
    input  logic [DGST_W-1:0] dgst,
    output logic              res_vld,
    output logic [DGST_W-1:0] res_dgst,
    input  logic              res_rdy
);

    sha2_state_e state, state_nxt;
    logic [31:0] remaining;
    logic [31:0] len_q;
    logic [2:0]  byte_cnt;
    logic        cmd_acc;
    logic        byte_acc;
    logic        word_clr;

    // Handshake outputs decode registered state only.
    assign cmd_rdy = (state == ST_IDLE);
    assign start_p = (state == ST_START);
    assign in_rdy  = (state == ST_PACK);
    assign msg_vld = (state == ST_SEND);
    assign res_vld = (state == ST_RESULT);
    assign msg_lst = (state == ST_SEND) && (remaining == '0);
    assign msg_be  = be_from_cnt(byte_cnt);
    assign msg_len = {29'b0, len_q, 3'b000};

    assign cmd_acc  = cmd_rdy && cmd_vld;
    assign byte_acc = in_rdy && in_vld;
    assign word_clr = cmd_acc || (msg_vld && msg_rdy && !msg_lst);

    sha2_byte_packer u_packer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (word_clr),
        .byte_vld (byte_acc),
        .byte_dat (in_dat),
        .word     (msg_dat),
        .byte_cnt (byte_cnt)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:      if (cmd_vld) state_nxt = ST_START;
            ST_START:     state_nxt = (remaining == '0) ? ST_WAIT_DGST : ST_PACK;
            ST_PACK:      if (byte_acc && (byte_cnt == 3'd3 || remaining == 32'd1))
                              state_nxt = ST_SEND;
            ST_SEND:      if (msg_rdy) state_nxt = msg_lst ? ST_WAIT_DGST : ST_PACK;
            ST_WAIT_DGST: if (dgst_done) state_nxt = ST_RESULT;
            ST_RESULT:    if (res_rdy) state_nxt = ST_IDLE;
            default:      state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            remaining <= '0;
            len_q     <= '0;
            res_dgst  <= '0;
        end else begin
            state <= state_nxt;
            if (cmd_acc) begin
                remaining <= cmd_len;
                len_q     <= cmd_len;
            end else if (byte_acc) begin
                remaining <= remaining - 32'd1;
            end
            if (state == ST_WAIT_DGST && dgst_done)
                res_dgst <= dgst;
        end
    end

endmodule

// File: tb/tb_sha2_msg_sender.sv
// Directed bench for sha2_msg_sender; the testbench plays the hash core.
module tb_sha2_msg_sender;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         cmd_vld;
    logic [31:0]  cmd_len;
    logic         cmd_rdy;
    logic         in_vld;
    logic [7:0]   in_dat;
    logic         in_rdy;
    logic         start_p;
    logic [63:0]  msg_len;
    logic         msg_vld;
    logic [31:0]  msg_dat;
    logic [3:0]   msg_be;
    logic         msg_lst;
    logic         msg_rdy;
    logic         dgst_done;
    logic [255:0] dgst;
    logic         res_vld;
    logic [255:0] res_dgst;
    logic         res_rdy;

    int vectors = 0;
    int miscompares = 0;

    localparam logic [255:0] D_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
    localparam logic [255:0] D_ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] D_FIVE  = 256'h0123456789abcdeffedcba98765432100f1e2d3c4b5a69788796a5b4c3d2e1f0;
    localparam logic [255:0] D_JUNK  = 256'hdeadbeefdeadbeefdeadbeefdeadbeefdeadbeefdeadbeefdeadbeefdeadbeef;

    sha2_msg_sender dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_vld   (cmd_vld),
        .cmd_len   (cmd_len),
        .cmd_rdy   (cmd_rdy),
        .in_vld    (in_vld),
        .in_dat    (in_dat),
        .in_rdy    (in_rdy),
        .start_p   (start_p),
        .msg_len   (msg_len),
        .msg_vld   (msg_vld),
        .msg_dat   (msg_dat),
        .msg_be    (msg_be),
        .msg_lst   (msg_lst),
        .msg_rdy   (msg_rdy),
        .dgst_done (dgst_done),
        .dgst      (dgst),
        .res_vld   (res_vld),
        .res_dgst  (res_dgst),
        .res_rdy   (res_rdy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; cmd_vld = 1'b0; cmd_len = '0; in_vld = 1'b0; in_dat = '0;
        msg_rdy = 1'b0; dgst_done = 1'b0; dgst = '0; res_rdy = 1'b0;
        #12;
        chk("rst_cmd_rdy", 256'(cmd_rdy), 256'(1'b1));
        chk("rst_start_p", 256'(start_p), 256'(1'b0));
        chk("rst_msg_vld", 256'(msg_vld), 256'(1'b0));
        chk("rst_msg_lst", 256'(msg_lst), 256'(1'b0));
        chk("rst_in_rdy", 256'(in_rdy), 256'(1'b0));
        chk("rst_res_vld", 256'(res_vld), 256'(1'b0));
        chk("rst_msg_dat", 256'(msg_dat), 256'(32'h0));
        chk("rst_msg_be", 256'(msg_be), 256'(4'h0));
        chk("rst_msg_len", 256'(msg_len), 256'(64'h0));
        chk("rst_res_dgst", res_dgst, 256'h0);
        rst_n = 1'b1;
        tick();

        // Empty message: START then straight to waiting for the digest.
        cmd_vld = 1'b1; cmd_len = 32'd0;
        tick();
        cmd_vld = 1'b0;
        chk("len0_start_p", 256'(start_p), 256'(1'b1));
        chk("len0_msg_len", 256'(msg_len), 256'(64'd0));
        chk("len0_cmd_rdy", 256'(cmd_rdy), 256'(1'b0));
        tick();
        chk("len0_start_p_off", 256'(start_p), 256'(1'b0));
        chk("len0_msg_vld", 256'(msg_vld), 256'(1'b0));
        tick();
        chk("len0_msg_vld2", 256'(msg_vld), 256'(1'b0));
        dgst_done = 1'b1; dgst = D_EMPTY;
        tick();
        dgst_done = 1'b0; dgst = '0;
        chk("len0_res_vld", 256'(res_vld), 256'(1'b1));
        chk("len0_res_dgst", res_dgst, D_EMPTY);
        res_rdy = 1'b1;
        tick();
        res_rdy = 1'b0;
        chk("len0_res_vld_off", 256'(res_vld), 256'(1'b0));
        chk("len0_cmd_rdy_back", 256'(cmd_rdy), 256'(1'b1));

        // A stray digest in IDLE must not disturb the result register.
        dgst_done = 1'b1; dgst = D_JUNK;
        tick();
        dgst_done = 1'b0;
        chk("idle_dgst_ignored", res_dgst, D_EMPTY);
        chk("idle_no_result", 256'(res_vld), 256'(1'b0));

        // "abc": one partial, last word.
        cmd_vld = 1'b1; cmd_len = 32'd3;
        tick();
        cmd_vld = 1'b0;
        chk("abc_msg_len", 256'(msg_len), 256'(64'd24));
        tick();
        chk("abc_in_rdy", 256'(in_rdy), 256'(1'b1));
        in_vld = 1'b1; in_dat = 8'h61; tick();
        in_dat = 8'h62; tick();
        in_dat = 8'h63; tick();
        in_vld = 1'b0;
        chk("abc_msg_vld", 256'(msg_vld), 256'(1'b1));
        chk("abc_msg_dat", 256'(msg_dat), 256'(32'h61626300));
        chk("abc_msg_be", 256'(msg_be), 256'(4'he));
        chk("abc_msg_lst", 256'(msg_lst), 256'(1'b1));
        chk("abc_in_rdy_send", 256'(in_rdy), 256'(1'b0));
        chk("abc_msg_len_hold", 256'(msg_len), 256'(64'd24));
        msg_rdy = 1'b1;
        tick();
        msg_rdy = 1'b0;
        chk("abc_msg_vld_off", 256'(msg_vld), 256'(1'b0));
        dgst_done = 1'b1; dgst = D_ABC;
        tick();
        dgst_done = 1'b0; dgst = '0;
        chk("abc_res_dgst", res_dgst, D_ABC);
        res_rdy = 1'b1;
        tick();
        res_rdy = 1'b0;

        // Five bytes: a full word, a back-pressured send, then a 1-byte last word.
        cmd_vld = 1'b1; cmd_len = 32'd5;
        tick();
        cmd_vld = 1'b0;
        chk("five_msg_len", 256'(msg_len), 256'(64'd40));
        tick();
        in_vld = 1'b1; in_dat = 8'h61; tick();
        in_dat = 8'h62; tick();
        in_dat = 8'h63; tick();
        chk("five_lat_msg_vld_early", 256'(msg_vld), 256'(1'b0));
        in_dat = 8'h64; tick();
        in_dat = 8'h99;
        chk("five_lat_msg_vld", 256'(msg_vld), 256'(1'b1));
        dgst_done = 1'b1; dgst = D_JUNK;
        for (int i = 0; i < 3; i++) begin
            chk("stall_msg_vld", 256'(msg_vld), 256'(1'b1));
            chk("stall_msg_dat", 256'(msg_dat), 256'(32'h61626364));
            chk("stall_msg_be", 256'(msg_be), 256'(4'hf));
            chk("stall_msg_lst", 256'(msg_lst), 256'(1'b0));
            chk("stall_in_rdy", 256'(in_rdy), 256'(1'b0));
            tick();
        end
        dgst_done = 1'b0; in_vld = 1'b0;
        msg_rdy = 1'b1;
        tick();
        msg_rdy = 1'b0;
        chk("five_pack2_in_rdy", 256'(in_rdy), 256'(1'b1));
        chk("five_pack2_cleared", 256'(msg_dat), 256'(32'h0));
        in_vld = 1'b1; in_dat = 8'h65; tick();
        in_vld = 1'b0;
        chk("five_w2_msg_vld", 256'(msg_vld), 256'(1'b1));
        chk("five_w2_msg_dat", 256'(msg_dat), 256'(32'h65000000));
        chk("five_w2_msg_be", 256'(msg_be), 256'(4'h8));
        chk("five_w2_msg_lst", 256'(msg_lst), 256'(1'b1));
        msg_rdy = 1'b1;
        tick();
        msg_rdy = 1'b0;
        dgst_done = 1'b1; dgst = D_FIVE;
        tick();
        dgst_done = 1'b0; dgst = '0;
        for (int i = 0; i < 5; i++) begin
            chk("hold_res_vld", 256'(res_vld), 256'(1'b1));
            chk("hold_res_dgst", res_dgst, D_FIVE);
            tick();
        end
        rst_n = 1'b0;
        #2;
        chk("rstpulse_res_vld", 256'(res_vld), 256'(1'b0));
        rst_n = 1'b1;
        tick();
        chk("rstpulse_cmd_rdy", 256'(cmd_rdy), 256'(1'b1));
        chk("rstpulse_res_vld_after", 256'(res_vld), 256'(1'b0));
        chk("rstpulse_res_dgst", res_dgst, 256'h0);

        // Reset in the middle of packing abandons the job.
        cmd_vld = 1'b1; cmd_len = 32'd8;
        tick();
        cmd_vld = 1'b0;
        tick();
        in_vld = 1'b1; in_dat = 8'h11; tick();
        in_dat = 8'h22; tick();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        tick();
        chk("midjob_cmd_rdy", 256'(cmd_rdy), 256'(1'b1));
        for (int i = 0; i < 4; i++) begin
            chk("midjob_no_msg_vld", 256'(msg_vld), 256'(1'b0));
            chk("midjob_no_in_rdy", 256'(in_rdy), 256'(1'b0));
            tick();
        end
        in_vld = 1'b0;
        chk("midjob_msg_dat", 256'(msg_dat), 256'(32'h0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
